mem_access: RTL and testbench

Memory-access stage of the RISC-V pipeline. Sits directly downstream of the EX/MEM pipeline register and consumes its load/store request, writeback fields and instruction word. Performs aligned byte/half/word loads and stores over a request/acknowledge data bus, and extends load data. Stalls upstream stages through `hold_o` until the bus transaction completes, then presents writeback data to the MEM/WB register.

---
 rtl/mem_access.sv | 191 +++++++++++++++++++
 tb/tb_mem_access.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access.sv
`timescale 1ns/1ps
// Memory-access pipeline stage: aligned B/H/W loads and stores over a req/ack
// data bus, with load extension, upstream stall, misalignment and timeout reporting.
module mem_access #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk_100MHz,
  input  logic        arst_n,
  input  logic        mem_r_ena_i,
  input  logic [31:0] mem_r_addr_i,
  input  logic        mem_w_ena_i,
  input  logic [31:0] mem_w_addr_i,
  input  logic [31:0] mem_w_data_i,
  input  logic [31:0] inst_i,
  input  logic [4:0]  reg_w_addr_i,
  input  logic        reg_w_ena_i,
  input  logic [31:0] reg_w_data_i,
  output logic        dbus_req_o,
  output logic        dbus_we_o,
  output logic [31:0] dbus_addr_o,
  output logic [3:0]  dbus_be_o,
  output logic [31:0] dbus_wdata_o,
  input  logic [31:0] dbus_rdata_i,
  input  logic        dbus_ack_i,
  output logic [4:0]  reg_w_addr_o,
  output logic        reg_w_ena_o,
  output logic [31:0] reg_w_data_o,
  output logic        hold_o,
  output logic        misalign_o,
  output logic        bus_err_o
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_DONE} state_e;

  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_e      state_q, state_d;
  logic        req_q, req_d, we_q, we_d, abort_q, abort_d;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d;
  logic [3:0]  be_q, be_d;
  logic [7:0]  cnt_q, cnt_d;

  logic        is_store, acc_en, sz_b, sz_h, misaligned;
  logic [2:0]  funct3;
  logic [31:0] acc_addr, st_wdata, ld_data;
  logic [3:0]  st_be;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic        hold, misalign, bus_err, w_ena;
  logic [31:0] w_data;
  logic        unused_inst;

  assign unused_inst = ^{inst_i[31:15], inst_i[11:0]};
  assign funct3      = inst_i[14:12];
  assign is_store    = mem_w_ena_i;
  assign acc_en      = mem_w_ena_i | mem_r_ena_i;
  assign acc_addr    = is_store ? mem_w_addr_i : mem_r_addr_i;

  // Loads use funct3[2] as the unsigned flag, so only stores decode all three bits.
  always_comb begin
    if (is_store) begin
      sz_b = (funct3 == 3'b000);
      sz_h = (funct3 == 3'b001);
    end else begin
      sz_b = (funct3[1:0] == 2'b00);
      sz_h = (funct3[1:0] == 2'b01);
    end
  end

  assign misaligned = sz_h ? acc_addr[0] : (!sz_b && acc_addr[1:0] != 2'b00);
  assign st_be      = sz_b ? (4'b0001 << acc_addr[1:0])
                    : sz_h ? (acc_addr[1] ? 4'b1100 : 4'b0011) : 4'b1111;
  assign st_wdata   = sz_b ? {4{mem_w_data_i[7:0]}}
                    : sz_h ? {2{mem_w_data_i[15:0]}} : mem_w_data_i;

  // EX/MEM is stalled during REQ, so the live load address and funct3 are valid at ack.
  assign ld_byte = dbus_rdata_i[{mem_r_addr_i[1:0], 3'b000} +: 8];
  assign ld_half = dbus_rdata_i[{mem_r_addr_i[1], 4'b0000} +: 16];
  always_comb begin
    unique case (funct3[1:0])
      2'b00:   ld_data = {{24{~funct3[2] & ld_byte[7]}}, ld_byte};
      2'b01:   ld_data = {{16{~funct3[2] & ld_half[15]}}, ld_half};
      default: ld_data = dbus_rdata_i;
    endcase
  end

  always_comb begin
    // NOTE: every combinational output gets a default first so no path infers a latch.
    state_d  = state_q;
    req_d    = req_q;
    we_d     = we_q;
    addr_d   = addr_q;
    be_d     = be_q;
    wdata_d  = wdata_q;
    cnt_d    = cnt_q;
    rdata_d  = rdata_q;
    abort_d  = abort_q;
    hold     = 1'b0;
    misalign = 1'b0;
    bus_err  = 1'b0;
    w_ena    = reg_w_ena_i;
    w_data   = reg_w_data_i;
    unique case (state_q)
      S_IDLE: begin
        if (acc_en) begin
          w_ena = 1'b0;
          if (misaligned) begin
            misalign = 1'b1;
          end else begin
            hold    = 1'b1;
            state_d = S_REQ;
            req_d   = 1'b1;
            we_d    = is_store;
            addr_d  = {acc_addr[31:2], 2'b00};
            be_d    = is_store ? st_be : 4'b1111;
            wdata_d = is_store ? st_wdata : 32'h0;
          end
        end
      end
      S_REQ: begin
        hold  = 1'b1;
        w_ena = 1'b0;
        if (dbus_ack_i) begin
          req_d   = 1'b0;
          rdata_d = ld_data;
          cnt_d   = 8'd0;
          state_d = S_DONE;
        end else if (cnt_q == TMO_LAST) begin
          req_d   = 1'b0;
          abort_d = 1'b1;
          cnt_d   = 8'd0;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        abort_d = 1'b0;
        bus_err = abort_q;
        if (we_q) begin
          w_ena = 1'b0;
        end else begin
          w_ena  = reg_w_ena_i & ~abort_q;
          w_data = rdata_q;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_100MHz or negedge arst_n) begin
    if (!arst_n) begin
      state_q <= S_IDLE;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= 32'h0;
      be_q    <= 4'h0;
      wdata_q <= 32'h0;
      cnt_q   <= 8'd0;
      rdata_q <= 32'h0;
      abort_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q <= state_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      abort_q <= abort_d;
    end
  end

  assign dbus_req_o   = req_q;
  assign dbus_we_o    = we_q;
  assign dbus_addr_o  = addr_q;
  assign dbus_be_o    = be_q;
  assign dbus_wdata_o = wdata_q;

  // The pass-through path would otherwise leak EX/MEM values while reset is asserted.
  assign hold_o       = arst_n & hold;
  assign misalign_o   = arst_n & misalign;
  assign bus_err_o    = arst_n & bus_err;
  assign reg_w_ena_o  = arst_n & w_ena;
  assign reg_w_addr_o = arst_n ? reg_w_addr_i : 5'd0;
  assign reg_w_data_o = arst_n ? w_data : 32'h0;

endmodule

// File: tb/tb_mem_access.sv
`timescale 1ns/1ps
// Self-checking bench for mem_access: directed cases plus randomized accesses
// compared against an arithmetic model of sizes, lanes, extension and latency.
module tb_mem_access;

  localparam int TMO = 4;

  logic        clk_100MHz = 1'b0;
  logic        arst_n = 1'b1;
  logic        mem_r_ena_i, mem_w_ena_i, reg_w_ena_i, dbus_ack_i;
  logic [31:0] mem_r_addr_i, mem_w_addr_i, mem_w_data_i, inst_i, reg_w_data_i, dbus_rdata_i;
  logic [4:0]  reg_w_addr_i;
  logic        dbus_req_o, dbus_we_o, reg_w_ena_o, hold_o, misalign_o, bus_err_o;
  logic [31:0] dbus_addr_o, dbus_wdata_o, reg_w_data_o;
  logic [3:0]  dbus_be_o;
  logic [4:0]  reg_w_addr_o;

  int n_checks = 0;
  int n_errors = 0;

  mem_access #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk_100MHz(clk_100MHz), .arst_n(arst_n),
    .mem_r_ena_i(mem_r_ena_i), .mem_r_addr_i(mem_r_addr_i),
    .mem_w_ena_i(mem_w_ena_i), .mem_w_addr_i(mem_w_addr_i), .mem_w_data_i(mem_w_data_i),
    .inst_i(inst_i), .reg_w_addr_i(reg_w_addr_i), .reg_w_ena_i(reg_w_ena_i),
    .reg_w_data_i(reg_w_data_i),
    .dbus_req_o(dbus_req_o), .dbus_we_o(dbus_we_o), .dbus_addr_o(dbus_addr_o),
    .dbus_be_o(dbus_be_o), .dbus_wdata_o(dbus_wdata_o), .dbus_rdata_i(dbus_rdata_i),
    .dbus_ack_i(dbus_ack_i),
    .reg_w_addr_o(reg_w_addr_o), .reg_w_ena_o(reg_w_ena_o), .reg_w_data_o(reg_w_data_o),
    .hold_o(hold_o), .misalign_o(misalign_o), .bus_err_o(bus_err_o)
  );

  always #5 clk_100MHz = ~clk_100MHz;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Access size in bytes as implied by direction and funct3.
  function automatic int m_size(input logic st, input logic [2:0] f3);
    if (st) return (f3 == 3'd0) ? 1 : (f3 == 3'd1) ? 2 : 4;
    return (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
  endfunction

  function automatic logic [3:0] m_be(input logic st, input int sz, input int lo);
    int v;
    if (!st || sz == 4) return 4'hF;
    v = ((1 << sz) - 1) << lo;
    return 4'(v);
  endfunction

  function automatic logic [31:0] m_wdata(input int sz, input logic [31:0] d);
    if (sz == 1) return (d % 256) * 32'h0101_0101;
    if (sz == 2) return (d % 65536) * 32'h0001_0001;
    return d;
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] f3, input int lo, input logic [31:0] w);
    logic [31:0] v;
    if (f3[1:0] == 2'd0) begin
      v = (w >> (8 * lo)) % 256;
      if (!f3[2] && v >= 128) v = v - 256;
    end else if (f3[1:0] == 2'd1) begin
      v = (w >> (16 * (lo / 2))) % 65536;
      if (!f3[2] && v >= 32768) v = v - 65536;
    end else begin
      v = w;
    end
    return v;
  endfunction

  task automatic idle_inputs();
    mem_r_ena_i = 1'b0;
    mem_w_ena_i = 1'b0;
    dbus_ack_i  = 1'b0;
  endtask

  // Non-memory instruction: same-cycle pass-through; a stray ack must be ignored.
  task automatic run_alu(input logic [31:0] d);
    idle_inputs();
    reg_w_data_i = d;
    reg_w_addr_i = 5'($urandom);
    reg_w_ena_i  = 1'($urandom);
    dbus_ack_i   = 1'($urandom);
    @(negedge clk_100MHz);
    check("alu_data", reg_w_data_o, d);
    check("alu_addr", reg_w_addr_o, reg_w_addr_i);
    check("alu_ena", reg_w_ena_o, reg_w_ena_i);
    check("alu_hold_req_mis", {hold_o, dbus_req_o, misalign_o}, 3'b000);
    @(posedge clk_100MHz); #1;
    dbus_ack_i = 1'b0;
  endtask

  // ack_after = wait cycles before ack; ack_after < 0 or >= TMO means no ack.
  task automatic run_op(input logic st, input logic [31:0] addr, input logic [31:0] d,
                        input logic [2:0] f3, input int ack_after, input logic [31:0] rword,
                        input logic [4:0] rd, input logic wen);
    int   sz, lo, nreq, hold_cnt;
    logic mis, abort_e;
    sz  = m_size(st, f3);
    lo  = int'(addr % 4);
    mis = (addr % sz) != 0;
    mem_w_ena_i  = st;
    mem_r_ena_i  = st ? 1'($urandom) : 1'b1;
    mem_w_addr_i = st ? addr : $urandom;
    mem_r_addr_i = st ? $urandom : addr;
    mem_w_data_i = d;
    inst_i       = $urandom;
    inst_i[14:12] = f3;
    reg_w_addr_i = rd;
    reg_w_ena_i  = wen;
    reg_w_data_i = $urandom;
    dbus_ack_i   = 1'b0;
    dbus_rdata_i = $urandom;
    @(negedge clk_100MHz);
    check("misalign", misalign_o, mis);
    check("idle_hold", hold_o, !mis);
    check("idle_noreq", dbus_req_o, 1'b0);
    if (mis) begin
      check("mis_wena", reg_w_ena_o, 1'b0);
      @(posedge clk_100MHz); #1;
      check("mis_noreq", dbus_req_o, 1'b0);
      idle_inputs();
      return;
    end
    hold_cnt = 1;
    @(posedge clk_100MHz); #1;
    check("bus_addr", dbus_addr_o, addr - (addr % 4));
    check("bus_be", dbus_be_o, m_be(st, sz, lo));
    check("bus_we", dbus_we_o, st);
    if (st) check("bus_wdata", dbus_wdata_o, m_wdata(sz, d));
    abort_e = !(ack_after >= 0 && ack_after < TMO);
    nreq    = abort_e ? TMO : ack_after + 1;
    for (int i = 0; i < nreq; i++) begin
      dbus_ack_i   = (i == ack_after);
      dbus_rdata_i = (i == ack_after) ? rword : $urandom;
      @(negedge clk_100MHz);
      check("req_hold", {hold_o, dbus_req_o}, 2'b11);
      hold_cnt += int'(hold_o);
      @(posedge clk_100MHz); #1;
      dbus_ack_i = 1'b0;
    end
    dbus_ack_i = 1'($urandom);
    @(negedge clk_100MHz);
    check("hold_cycles", hold_cnt, nreq + 1);
    check("done_hold_req", {hold_o, dbus_req_o}, 2'b00);
    check("done_buserr", bus_err_o, abort_e);
    check("done_waddr", reg_w_addr_o, rd);
    check("done_wena", reg_w_ena_o, !st && wen && !abort_e);
    if (!st && !abort_e) check("done_wdata", reg_w_data_o, m_load(f3, lo, rword));
    @(posedge clk_100MHz); #1;
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    mem_r_addr_i = 32'h0; mem_w_addr_i = 32'h0; mem_w_data_i = 32'h0; inst_i = 32'h0;
    reg_w_addr_i = 5'd0; reg_w_ena_i = 1'b0; reg_w_data_i = 32'h0; dbus_rdata_i = 32'h0;

    // Reset with live, enabled inputs: every output must read zero.
    #1 arst_n = 1'b0;
    mem_r_ena_i = 1'b1; mem_r_addr_i = 32'h0000_3002; inst_i = 32'h0000_2003;
    reg_w_ena_i = 1'b1; reg_w_addr_i = 5'd7; reg_w_data_i = 32'hDEAD_BEEF;
    #3;
    check("rst_outs", {hold_o, misalign_o, bus_err_o, reg_w_ena_o, dbus_req_o, dbus_we_o}, 6'b0);
    check("rst_waddr", reg_w_addr_o, 5'd0);
    check("rst_wdata", reg_w_data_o, 32'h0);
    check("rst_baddr", dbus_addr_o, 32'h0);
    check("rst_be_wdata", {dbus_be_o, dbus_wdata_o[27:0]}, 32'h0);
    idle_inputs();
    @(negedge clk_100MHz); arst_n = 1'b1;
    @(posedge clk_100MHz); #1;

    run_alu(32'h0000_1234);
    run_op(1'b1, 32'h0000_1003, 32'h0000_00AB, 3'b000, 0, 32'h0, 5'd3, 1'b1);   // SB
    run_op(1'b0, 32'h0000_2002, 32'h0, 3'b000, 3, 32'h00F0_0000, 5'd5, 1'b1);   // LB
    run_op(1'b0, 32'h0000_2002, 32'h0, 3'b100, 3, 32'h00F0_0000, 5'd5, 1'b1);   // LBU
    run_op(1'b0, 32'h0000_3002, 32'h0, 3'b010, 0, 32'h0, 5'd6, 1'b1);           // LW misaligned
    run_op(1'b0, 32'h0000_4000, 32'h0, 3'b010, -1, 32'h0, 5'd8, 1'b1);          // LW timeout
    run_op(1'b1, 32'h0000_0042, 32'h1234_8765, 3'b001, 1, 32'h0, 5'd1, 1'b1);   // SH upper half
    run_op(1'b0, 32'h0000_0046, 32'h0, 3'b001, 0, 32'h8001_7FFF, 5'd9, 1'b1);   // LH upper half

    // Reset during the second REQ cycle abandons the transaction immediately.
    mem_r_ena_i = 1'b1; mem_w_ena_i = 1'b0; mem_r_addr_i = 32'h0000_0040;
    inst_i = 32'h0000_2003; reg_w_ena_i = 1'b1; reg_w_addr_i = 5'd4;
    @(posedge clk_100MHz); #1;
    @(posedge clk_100MHz); #2;
    arst_n = 1'b0;
    #1;
    check("midreq_rst_req_hold", {dbus_req_o, hold_o}, 2'b00);
    check("midreq_rst_wena", reg_w_ena_o, 1'b0);
    idle_inputs();
    @(negedge clk_100MHz); arst_n = 1'b1;
    @(posedge clk_100MHz); #1;
    run_op(1'b0, 32'h0000_0010, 32'h0, 3'b001, 0, 32'h0000_C0DE, 5'd2, 1'b1);   // LH after reset

    for (int k = 0; k < 200; k++) begin
      if ($urandom_range(0, 3) == 0) begin
        run_alu($urandom);
      end else begin
        logic [31:0] a;
        a = $urandom;
        if ($urandom_range(0, 1) == 0) a[1:0] = 2'b00;
        run_op(1'($urandom), a, $urandom, 3'($urandom), $urandom_range(0, TMO),
               $urandom, 5'($urandom), 1'($urandom));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
